apb_mem_a_bridge: RTL and testbench
===================================

Name: apb_mem_a_bridge

Overview:
- APB completer sitting directly downstream of the top-level APB decoder on the uBlockA leg (addr_id_top = ADDR_ID_TOP_UBLOCKA).
- Converts 32-bit APB register accesses into full-width accesses to memory A (MEMORYA_WORDS x MEMORYA_WIDTH = 19 x 63 bits).
- Each memory word is exposed as two APB words, LO then HI; staging and holding registers keep the accesses atomic.

Parameters:
- WORDS, 19 (MEMORYA_WORDS): number of valid memory lines.
- ADDR_W, 5 (MEMORYA_WORDS_LOG2): memory address width.
- DATA_W, 63 (MEMORYA_WIDTH): memory data width; must satisfy 32 < DATA_W <= 64.
- APB_W, 32 (DWORD): APB address/data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- psel  in  1  APB select (from decoder).
- penable  in  1  APB access phase.
- pwrite  in  1  APB write.
- paddr  in  APB_W  byte address; only [ADDR_W+2:0] decoded, upper bits ignored.
- pwdata  in  APB_W  write data.
- prdata  out  APB_W  read data, registered.
- pready  out  1  transfer complete.
- pslverr  out  1  error, valid with pready.
- mem_addr  out  ADDR_W  memory line index.
- mem_we  out  1  memory write strobe, one cycle.
- mem_wdata  out  DATA_W  memory write data.
- mem_re  out  1  memory read strobe, one cycle.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re.

Behaviour:
- Decode: idx = paddr[ADDR_W+2:3]; hi = paddr[2]. Error when paddr[1:0] != 0 or idx >= WORDS.
- HI half = mem bits [DATA_W-1:32], zero-extended on read; pwdata bits above DATA_W-33 are discarded on write.
- Registers:
  - wlo_q (32 bits): staged LO write data.
  - rhi_q (DATA_W-32 bits): HI half captured by the last LO read.
  - lo_vld_q: set by a LO write, cleared by a HI write or reset.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE, psel & penable:
  - Error: pready=1, pslverr=1 in the same cycle; no memory strobe; state unchanged.
  - Write LO: wlo_q <= pwdata, lo_vld_q <= 1, pready=1 (zero wait states).
  - Write HI: mem_we=1, mem_addr=idx, mem_wdata={pwdata[DATA_W-33:0], wlo_q}, pready=1; lo_vld_q <= 0.
  - Read LO: mem_re=1, mem_addr=idx, go to RD_WAIT, pready=0.
  - Read HI: prdata <= rhi_q (zero-extended), go to RESP (1 wait state).
- RD_WAIT: prdata <= mem_rdata[31:0], rhi_q <= mem_rdata[DATA_W-1:32], go to RESP.
- RESP: pready=1, pslverr=0, go to IDLE. Read LO latency is 2 wait states; read HI is 1.
- pready, pslverr, mem_we and mem_re are combinational decodes of state and inputs, 0 whenever not stated above.
- psel deasserted mid-transfer (protocol violation): FSM still completes to IDLE; the outstanding read result is discarded, and rhi_q is still updated.
- HI read with no prior LO read: returns rhi_q (0 after reset).
- Two consecutive LO writes: the last one wins.
- A HI write to index j after a LO write to index i commits wlo_q to line j (index not checked).
- Reset (any state, mid-transfer included): FSM=IDLE; prdata, wlo_q, rhi_q, lo_vld_q = 0; all outputs 0.

Optional Feature:
- APB_MEM_A_SEQCHK_EN defined: a HI write with lo_vld_q=0 returns pslverr=1 with no mem_we, and a HI read is an error unless the previous completed read was a LO read to the same idx (tracked in a last_idx_q register plus a valid bit).
- Undefined: no sequence checking; behaviour is exactly as above.

Decomposition:
- Shared package: MEMORYA_WORDS, MEMORYA_WORDS_LOG2, MEMORYA_WIDTH, DWORD; types aAddrBitsT, aDataBitsT, apbAddrT, apbDataT; new enum apbMemABridgeStateT {IDLE, RD_WAIT, RESP}.
- No sub-module; a flat single module is natural.

Test Plan:
- Write LO 0x0000_0008 = 0xDEAD_BEEF, then HI 0x0000_000C = 0x1234_5678 -> single mem_we, mem_addr=1, mem_wdata=0x1234_5678_DEAD_BEEF masked to 63 bits; both writes pready with 0 wait.
- Read LO 0x08 -> mem_re in the access cycle, pready on the 3rd access cycle, prdata=0xDEAD_BEEF; then read HI 0x0C -> prdata=0x1234_5678 after 1 wait state, no mem_re.
- Access 0x98 (idx 19) and 0x0A (misaligned) -> pready=1, pslverr=1 immediately, no memory strobes.
- Boundary idx 18 (0x90/0x94) write then read of all-ones -> LO 0xFFFF_FFFF, HI 0x7FFF_FFFF.
- Assert rst during RD_WAIT -> next cycle all outputs 0, FSM in IDLE; a following HI read returns 0.
- With APB_MEM_A_SEQCHK_EN: HI write after reset with no prior LO write -> pslverr=1, no mem_we. Without the macro: mem_we fires with LO half = 0.

Source files
------------

// File: rtl/apb_mem_a_bridge_pkg.sv
// Shared memory-A geometry, APB widths and the bridge FSM state type.
package apb_mem_a_bridge_pkg;

    localparam int unsigned MEMORYA_WORDS      = 19;
    localparam int unsigned MEMORYA_WORDS_LOG2 = 5;
    localparam int unsigned MEMORYA_WIDTH      = 63;
    localparam int unsigned DWORD              = 32;

    typedef logic [MEMORYA_WORDS_LOG2-1:0] aAddrBitsT;
    typedef logic [MEMORYA_WIDTH-1:0]      aDataBitsT;
    typedef logic [DWORD-1:0]              apbAddrT;
    typedef logic [DWORD-1:0]              apbDataT;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } apbMemABridgeStateT;

endpackage

// File: rtl/apb_mem_a_bridge.sv
// APB completer exposing each memory-A line as a LO/HI pair of 32-bit words.
// Optional `APB_MEM_A_SEQCHK_EN enforces LO-before-HI access ordering.
module apb_mem_a_bridge
    import apb_mem_a_bridge_pkg::*;
#(
    parameter int unsigned WORDS  = MEMORYA_WORDS,
    parameter int unsigned ADDR_W = MEMORYA_WORDS_LOG2,
    parameter int unsigned DATA_W = MEMORYA_WIDTH,
    parameter int unsigned APB_W  = DWORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_W-1:0]  paddr,
    input  logic [APB_W-1:0]  pwdata,
    output logic [APB_W-1:0]  prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    apbMemABridgeStateT state, stateNext;

    logic [31:0]        wlo_q;
    logic [DATA_W-33:0] rhi_q;
    logic               lo_vld_q;

    logic [ADDR_W-1:0] idx;
    logic              hiSel, addrErr, seqErr;
    logic              wloLoad, hiWrite, hiRead, loRead;

    assign idx     = paddr[ADDR_W+2:3];
    assign hiSel   = paddr[2];
    assign addrErr = (paddr[1:0] != 2'b00) || (int'(idx) >= int'(WORDS));

    logic unusedBits;
    if (DATA_W < 64) begin : gUnusedNarrow
        assign unusedBits = ^{paddr[APB_W-1:ADDR_W+3], pwdata[APB_W-1:DATA_W-32]};
    end else begin : gUnusedFull
        assign unusedBits = ^paddr[APB_W-1:ADDR_W+3];
    end

`ifdef APB_MEM_A_SEQCHK_EN
    // Index of the last completed LO read; a HI read is only legal against it.
    logic [ADDR_W-1:0] last_idx_q;
    logic              last_vld_q;

    assign seqErr = hiSel && (pwrite ? !lo_vld_q : !(last_vld_q && (last_idx_q == idx)));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx_q <= '0;
            last_vld_q <= 1'b0;
        end else if (loRead) begin
            last_idx_q <= idx;
            last_vld_q <= 1'b1;
        end else if (hiRead) begin
            last_vld_q <= 1'b0;
        end
    end
`else
    assign seqErr = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        pready    = 1'b0;
        pslverr   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wloLoad   = 1'b0;
        hiWrite   = 1'b0;
        hiRead    = 1'b0;
        loRead    = 1'b0;
        unique case (state)
            IDLE: begin
                if (psel && penable) begin
                    if (addrErr || seqErr) begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end else if (pwrite && !hiSel) begin
                        wloLoad = 1'b1;
                        pready  = 1'b1;
                    end else if (pwrite) begin
                        mem_we    = 1'b1;
                        mem_addr  = idx;
                        mem_wdata = {pwdata[DATA_W-33:0], wlo_q};
                        pready    = 1'b1;
                        hiWrite   = 1'b1;
                    end else if (!hiSel) begin
                        mem_re    = 1'b1;
                        mem_addr  = idx;
                        loRead    = 1'b1;
                        stateNext = RD_WAIT;
                    end else begin
                        hiRead    = 1'b1;
                        stateNext = RESP;
                    end
                end
            end
            RD_WAIT: stateNext = RESP;
            RESP: begin
                pready    = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // RD_WAIT captures regardless of psel so rhi_q tracks the last LO read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prdata   <= '0;
            wlo_q    <= '0;
            rhi_q    <= '0;
            lo_vld_q <= 1'b0;
        end else begin
            state <= stateNext;
            if (wloLoad) begin
                wlo_q    <= pwdata[31:0];
                lo_vld_q <= 1'b1;
            end
            if (hiWrite) lo_vld_q <= 1'b0;
            if (hiRead) prdata <= APB_W'(rhi_q);
            if (state == RD_WAIT) begin
                prdata <= APB_W'(mem_rdata[31:0]);
                rhi_q  <= mem_rdata[DATA_W-1:32];
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_a_bridge.sv
// Scoreboard bench for apb_mem_a_bridge; honours `APB_MEM_A_SEQCHK_EN when defined.
module tb_apb_mem_a_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [4:0]  mem_addr;
    logic        mem_we, mem_re;
    logic [62:0] mem_wdata, mem_rdata;

    int unsigned nChecks = 0;
    int unsigned nFails  = 0;

    typedef struct {
        logic        chkData;
        logic [31:0] data;
        logic        err;
        int unsigned waits;
    } respT;

    typedef struct {
        logic [4:0]  addr;
        logic [62:0] data;
    } wrT;

    respT        respQ[$];
    wrT          wrQ[$];
    logic [4:0]  reQ[$];

    logic [62:0] memModel [0:31];
    logic [62:0] rdReg;

    apb_mem_a_bridge dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory A: read data appears exactly one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) memModel[mem_addr] <= mem_wdata;
        if (mem_re) rdReg <= memModel[mem_addr];
    end
    assign mem_rdata = rdReg;

    // Response monitor: counts access cycles and checks each completion.
    int unsigned accCnt = 0;
    always @(negedge clk) begin
        if (psel && penable && !rst) begin
            if (pready) begin
                respT e;
                nChecks++;
                if (respQ.size() == 0) begin
                    nFails++;
                    $display("FAIL resp_unexpected: got pready at paddr=%h, expected none", paddr);
                end else begin
                    e = respQ.pop_front();
                    if (pslverr !== e.err || accCnt != e.waits ||
                        (e.chkData && prdata !== e.data)) begin
                        nFails++;
                        $display("FAIL resp paddr=%h: got err=%b waits=%0d data=%h, expected err=%b waits=%0d data=%h",
                                 paddr, pslverr, accCnt, prdata, e.err, e.waits, e.data);
                    end
                end
                accCnt = 0;
            end else begin
                accCnt++;
            end
        end else begin
            accCnt = 0;
        end
    end

    // Memory-strobe monitor.
    always @(negedge clk) begin
        if (mem_we) begin
            wrT w;
            nChecks++;
            if (wrQ.size() == 0) begin
                nFails++;
                $display("FAIL mem_we_unexpected: got addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                w = wrQ.pop_front();
                if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                    nFails++;
                    $display("FAIL mem_we: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_addr, mem_wdata, w.addr, w.data);
                end
            end
        end
        if (mem_re) begin
            logic [4:0] a;
            nChecks++;
            if (reQ.size() == 0) begin
                nFails++;
                $display("FAIL mem_re_unexpected: got addr=%0d, expected no read", mem_addr);
            end else begin
                a = reQ.pop_front();
                if (mem_addr !== a) begin
                    nFails++;
                    $display("FAIL mem_re: got addr=%0d, expected addr=%0d", mem_addr, a);
                end
            end
        end
    end

    task automatic pushResp(input logic chk, input logic [31:0] d, input logic e, input int unsigned w);
        respT r;
        r.chkData = chk; r.data = d; r.err = e; r.waits = w;
        respQ.push_back(r);
    endtask

    task automatic pushWr(input logic [4:0] a, input logic [62:0] d);
        wrT w;
        w.addr = a; w.data = d;
        wrQ.push_back(w);
    endtask

    task automatic apbXfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
        int unsigned n = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (!pready && n < 20);
        if (n >= 20) begin
            nChecks++; nFails++;
            $display("FAIL timeout paddr=%h: got no pready in 20 cycles, expected completion", a);
        end
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic checkIdle(input string name);
        nChecks++;
        if ({prdata, pready, pslverr, mem_we, mem_re, mem_addr, mem_wdata} !== '0) begin
            nFails++;
            $display("FAIL %s: got prdata=%h pready=%b pslverr=%b we=%b re=%b addr=%0d wdata=%h, expected all 0",
                     name, prdata, pready, pslverr, mem_we, mem_re, mem_addr, mem_wdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) memModel[i] = '0;
        rdReg = '0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkIdle("reset_state");

        // HI write straight after reset.
`ifdef APB_MEM_A_SEQCHK_EN
        pushResp(1'b0, '0, 1'b1, 0);
`else
        pushWr(5'd1, {31'h2AAA_5555, 32'h0});
        pushResp(1'b0, '0, 1'b0, 0);
`endif
        apbXfer(1'b1, 32'h0000_000C, 32'hAAAA_5555);

        // LO/HI write pair to line 1, then read back.
        pushResp(1'b0, '0, 1'b0, 0);
        apbXfer(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        pushWr(5'd1, {31'h1234_5678, 32'hDEAD_BEEF});
        pushResp(1'b0, '0, 1'b0, 0);
        apbXfer(1'b1, 32'h0000_000C, 32'h1234_5678);
        reQ.push_back(5'd1);
        pushResp(1'b1, 32'hDEAD_BEEF, 1'b0, 2);
        apbXfer(1'b0, 32'h0000_0008, '0);
        pushResp(1'b1, 32'h1234_5678, 1'b0, 1);
        apbXfer(1'b0, 32'h0000_000C, '0);

        // Out-of-range and misaligned accesses.
        pushResp(1'b0, '0, 1'b1, 0);
        apbXfer(1'b0, 32'h0000_0098, '0);
        pushResp(1'b0, '0, 1'b1, 0);
        apbXfer(1'b1, 32'h0000_000A, 32'h5555_5555);
        pushResp(1'b0, '0, 1'b1, 0);
        apbXfer(1'b1, 32'h0000_0098, 32'h5555_5555);
        pushResp(1'b0, '0, 1'b1, 0);
        apbXfer(1'b0, 32'h0000_000A, '0);

        // Last line, all ones.
        pushResp(1'b0, '0, 1'b0, 0);
        apbXfer(1'b1, 32'h0000_0090, 32'hFFFF_FFFF);
        pushWr(5'd18, {63{1'b1}});
        pushResp(1'b0, '0, 1'b0, 0);
        apbXfer(1'b1, 32'h0000_0094, 32'hFFFF_FFFF);
        reQ.push_back(5'd18);
        pushResp(1'b1, 32'hFFFF_FFFF, 1'b0, 2);
        apbXfer(1'b0, 32'h0000_0090, '0);
        pushResp(1'b1, 32'h7FFF_FFFF, 1'b0, 1);
        apbXfer(1'b0, 32'h0000_0094, '0);

        // Two LO writes then HI to a different line; upper paddr bits ignored.
        pushResp(1'b0, '0, 1'b0, 0);
        apbXfer(1'b1, 32'h0000_0010, 32'h1111_1111);
        pushResp(1'b0, '0, 1'b0, 0);
        apbXfer(1'b1, 32'h0000_0010, 32'h2222_2222);
        pushWr(5'd3, {31'h0000_0003, 32'h2222_2222});
        pushResp(1'b0, '0, 1'b0, 0);
        apbXfer(1'b1, 32'h0000_001C, 32'h0000_0003);
        reQ.push_back(5'd3);
        pushResp(1'b1, 32'h2222_2222, 1'b0, 2);
        apbXfer(1'b0, 32'hF000_0018, '0);
        pushResp(1'b1, 32'h0000_0003, 1'b0, 1);
        apbXfer(1'b0, 32'h0000_001C, '0);

        // Reset while the FSM sits in RD_WAIT.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0008;
        @(posedge clk); #1;
        penable = 1'b1;
        reQ.push_back(5'd1);
        @(posedge clk); #1;
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkIdle("reset_in_rd_wait");
        @(posedge clk); #1 rst = 1'b0;
`ifdef APB_MEM_A_SEQCHK_EN
        pushResp(1'b0, '0, 1'b1, 0);
`else
        pushResp(1'b1, 32'h0, 1'b0, 1);
`endif
        apbXfer(1'b0, 32'h0000_000C, '0);

        repeat (3) @(posedge clk);
        nChecks++;
        if (respQ.size() != 0 || wrQ.size() != 0 || reQ.size() != 0) begin
            nFails++;
            $display("FAIL drain: got %0d resp %0d wr %0d re pending, expected 0",
                     respQ.size(), wrQ.size(), reQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
